// File: rtl/sdhci_reset_ctrl.sv
// SDHCI soft-reset sequencer: one global domain plus NumSub sub-domains, each held for
// HoldCycles, released glitch-free and followed by a self-clear strobe. Macro: SDHCI_AUTO_RST_EN.
module sdhci_reset_ctrl #(
  parameter int NumSub     = 2,
  parameter int HoldCycles = 4,
  parameter int CntWidth   = $clog2(HoldCycles + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sw_rst_all_i,
  input  logic [NumSub-1:0] sw_rst_sub_i,
  input  logic [NumSub-1:0] auto_rst_req_i,
  output logic              rst_all_no,
  output logic [NumSub-1:0] rst_sub_no,
  output logic              clr_all_de_o,
  output logic [NumSub-1:0] clr_sub_de_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, RELEASE = 2'd2} state_e;

  localparam logic [CntWidth-1:0] CntLast = CntWidth'(HoldCycles - 1);
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

  generate
    if (HoldCycles < 1) begin : g_bad_hold
      $error("sdhci_reset_ctrl: HoldCycles must be >= 1");
    end
    if (NumSub < 1 || NumSub > 8) begin : g_bad_sub
      $error("sdhci_reset_ctrl: NumSub must be in 1..8");
    end
  endgenerate

  state_e              g_state, g_next;
  logic [CntWidth-1:0] g_cnt, g_cnt_next;
  state_e              s_state    [NumSub];
  state_e              s_next     [NumSub];
  logic [CntWidth-1:0] s_cnt      [NumSub];
  logic [CntWidth-1:0] s_cnt_next [NumSub];
  logic                sw_all_q;
  logic [NumSub-1:0]   sw_sub_q;
  logic [NumSub-1:0]   auto_req;
  logic [NumSub-1:0]   sub_level;
  logic [NumSub-1:0]   sub_rise;
  logic                g_quiet;
  logic                sub_active;

`ifdef SDHCI_AUTO_RST_EN
  assign auto_req = auto_rst_req_i;
`else
  logic auto_unused;
  assign auto_unused = ^auto_rst_req_i;
  assign auto_req    = '0;
`endif

  // Idle entry is level-sensitive; a restart during HOLD needs a fresh rising bit or an auto pulse
  assign sub_level = sw_rst_sub_i | auto_req;
  assign sub_rise  = (sw_rst_sub_i & ~sw_sub_q) | auto_req;

  always_comb begin
    g_next     = g_state;
    g_cnt_next = g_cnt;
    case (g_state)
      IDLE: begin
        if (sw_rst_all_i) begin
          g_next     = HOLD;
          g_cnt_next = '0;
        end
      end
      HOLD: begin
        if (sw_rst_all_i && !sw_all_q) begin
          g_cnt_next = '0;
        end else if (g_cnt == CntLast) begin
          g_next = RELEASE;
        end else begin
          g_cnt_next = g_cnt + CntOne;
        end
      end
      RELEASE: g_next = IDLE;
      default: g_next = IDLE;
    endcase

    // Sub domains only run while the global domain is idle now and stays idle next cycle
    g_quiet    = (g_state == IDLE) && (g_next == IDLE);
    sub_active = 1'b0;
    for (int i = 0; i < NumSub; i++) begin
      s_next[i]     = s_state[i];
      s_cnt_next[i] = s_cnt[i];
      if (!g_quiet) begin
        s_next[i]     = IDLE;
        s_cnt_next[i] = '0;
      end else begin
        case (s_state[i])
          IDLE: begin
            if (sub_level[i]) begin
              s_next[i]     = HOLD;
              s_cnt_next[i] = '0;
            end
          end
          HOLD: begin
            if (sub_rise[i]) begin
              s_cnt_next[i] = '0;
            end else if (s_cnt[i] == CntLast) begin
              s_next[i] = RELEASE;
            end else begin
              s_cnt_next[i] = s_cnt[i] + CntOne;
            end
          end
          RELEASE: s_next[i] = IDLE;
          default: s_next[i] = IDLE;
        endcase
      end
      if (s_next[i] != IDLE) sub_active = 1'b1;
    end
  end

  // Outputs are registered from the next-state values so they line up with the state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      g_state      <= HOLD;
      g_cnt        <= '0;
      sw_all_q     <= 1'b0;
      sw_sub_q     <= '0;
      rst_all_no   <= 1'b0;
      rst_sub_no   <= '0;
      clr_all_de_o <= 1'b0;
      clr_sub_de_o <= '0;
      busy_o       <= 1'b1;
      for (int i = 0; i < NumSub; i++) begin
        s_state[i] <= IDLE;
        s_cnt[i]   <= '0;
      end
    end else begin
      g_state      <= g_next;
      g_cnt        <= g_cnt_next;
      sw_all_q     <= sw_rst_all_i;
      sw_sub_q     <= sw_rst_sub_i;
      rst_all_no   <= (g_next != HOLD);
      clr_all_de_o <= (g_next == RELEASE);
      busy_o       <= (g_next != IDLE) || sub_active;
      for (int i = 0; i < NumSub; i++) begin
        s_state[i]      <= s_next[i];
        s_cnt[i]        <= s_cnt_next[i];
        rst_sub_no[i]   <= !((s_next[i] == HOLD) || (g_next == HOLD));
        clr_sub_de_o[i] <= (s_next[i] == RELEASE);
      end
    end
  end

endmodule

// File: tb/tb_sdhci_reset_ctrl.sv
// Bench for sdhci_reset_ctrl: directed scenarios plus randomized traffic checked against a
// phase-count reference model. Honours SDHCI_AUTO_RST_EN the same way as the design.
module tb_sdhci_reset_ctrl;
  localparam int NS = 2;
  localparam int HC = 4;
`ifdef SDHCI_AUTO_RST_EN
  localparam bit AutoEn = 1'b1;
`else
  localparam bit AutoEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          sw_all;
  logic [NS-1:0] sw_sub;
  logic [NS-1:0] auto_req;
  logic          rst_all_n;
  logic [NS-1:0] rst_sub_n;
  logic          clr_all;
  logic [NS-1:0] clr_sub;
  logic          busy;

  always #5 clk = ~clk;

  sdhci_reset_ctrl #(.NumSub(NS), .HoldCycles(HC)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .sw_rst_all_i  (sw_all),
    .sw_rst_sub_i  (sw_sub),
    .auto_rst_req_i(auto_req),
    .rst_all_no    (rst_all_n),
    .rst_sub_no    (rst_sub_n),
    .clr_all_de_o  (clr_all),
    .clr_sub_de_o  (clr_sub),
    .busy_o        (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model phase per domain: 0 idle, 1..HC = n-th cycle in reset, HC+1 = release cycle
  int            m_g;
  int            m_s [NS];
  logic          m_all_q;
  logic [NS-1:0] m_sub_q;

  int cyc, cnt_all_low, cnt_clr_all, cnt_busy, t_clr_all, t_clr_sub1;
  int cnt_sub_low [NS];
  int cnt_clr_sub [NS];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int advance(input int p, input bit start, input bit restart);
    if (p == 0) return start ? 1 : 0;
    if (p <= HC) begin
      if (restart) return 1;
      return (p == HC) ? HC + 1 : p + 1;
    end
    return 0;
  endfunction

  function automatic void model_reset();
    m_g = 1;
    for (int i = 0; i < NS; i++) m_s[i] = 0;
    m_all_q = 1'b0;
    m_sub_q = '0;
  endfunction

  function automatic void model_step();
    int g_old;
    bit quiet;
    bit a;
    g_old = m_g;
    m_g   = advance(m_g, sw_all, sw_all && !m_all_q);
    quiet = (g_old == 0) && (m_g == 0);
    for (int i = 0; i < NS; i++) begin
      a = AutoEn && auto_req[i];
      if (!quiet) m_s[i] = 0;
      else m_s[i] = advance(m_s[i], sw_sub[i] || a, (sw_sub[i] && !m_sub_q[i]) || a);
    end
    m_all_q = sw_all;
    m_sub_q = sw_sub;
  endfunction

  task automatic clr_meas();
    cyc = 0; cnt_all_low = 0; cnt_clr_all = 0; cnt_busy = 0;
    t_clr_all = -1; t_clr_sub1 = -1;
    for (int i = 0; i < NS; i++) begin
      cnt_sub_low[i] = 0;
      cnt_clr_sub[i] = 0;
    end
  endtask

  task automatic compare_outputs();
    logic [NS-1:0] e_sub_n;
    logic [NS-1:0] e_clr_sub;
    bit g_hold;
    bit any;
    g_hold = (m_g >= 1) && (m_g <= HC);
    any    = (m_g != 0);
    for (int i = 0; i < NS; i++) begin
      e_sub_n[i]   = !(((m_s[i] >= 1) && (m_s[i] <= HC)) || g_hold);
      e_clr_sub[i] = (m_s[i] == HC + 1);
      if (m_s[i] != 0) any = 1'b1;
    end
    check_eq("rst_all_no", rst_all_n, !g_hold);
    check_eq("rst_sub_no", rst_sub_n, e_sub_n);
    check_eq("clr_all_de", clr_all, m_g == HC + 1);
    check_eq("clr_sub_de", clr_sub, e_clr_sub);
    check_eq("busy", busy, any);
    if (!rst) begin
      cyc++;
      cnt_all_low += int'(!rst_all_n);
      cnt_clr_all += int'(clr_all);
      cnt_busy    += int'(busy);
      if (clr_all && t_clr_all < 0) t_clr_all = cyc;
      if (clr_sub[1] && t_clr_sub1 < 0) t_clr_sub1 = cyc;
      for (int i = 0; i < NS; i++) begin
        cnt_sub_low[i] += int'(!rst_sub_n[i]);
        cnt_clr_sub[i] += int'(clr_sub[i]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  // Called right after a falling edge: asserts reset between edges and checks the outputs at once
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    compare_outputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    int exp_low;
    rst = 1'b1; sw_all = 1'b0; sw_sub = '0; auto_req = '0;
    model_reset();
    clr_meas();
    repeat (3) tick();
    check_eq("por_busy_in_reset", busy, 1);

    // Power-on hold
    rst = 1'b0;
    clr_meas();
    compare_outputs();
    repeat (7) tick();
    check_eq("por_all_low", cnt_all_low, HC);
    check_eq("por_sub0_low", cnt_sub_low[0], HC);
    check_eq("por_clr_all", cnt_clr_all, 1);
    check_eq("por_busy_cycles", cnt_busy, HC + 1);

    // Sub 0 software reset held until its clear strobe
    clr_meas();
    sw_sub = 2'b01;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (clr_sub[0]) seen = 1'b1;
    end
    sw_sub = '0;
    check_eq("s2_strobe_seen", seen, 1);
    repeat (6) tick();
    check_eq("s2_sub0_low", cnt_sub_low[0], HC);
    check_eq("s2_clr_sub0", cnt_clr_sub[0], 1);
    check_eq("s2_sub1_low", cnt_sub_low[1], 0);
    check_eq("s2_all_low", cnt_all_low, 0);

    // Global and sub 1 in the same cycle
    clr_meas();
    sw_all = 1'b1; sw_sub = 2'b10;
    tick();
    sw_all = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      tick();
      if (clr_sub[1]) seen = 1'b1;
    end
    sw_sub = '0;
    check_eq("s3_strobe_seen", seen, 1);
    repeat (4) tick();
    check_eq("s3_all_low", cnt_all_low, HC);
    check_eq("s3_sub1_low", cnt_sub_low[1], 2 * HC);
    check_eq("s3_sub0_low", cnt_sub_low[0], HC);
    check_eq("s3_clr_all", cnt_clr_all, 1);
    check_eq("s3_clr_sub1", cnt_clr_sub[1], 1);
    check_eq("s3_order", (t_clr_all > 0) && (t_clr_all < t_clr_sub1), 1);

    // Auto request during the second hold cycle of sub 0
    clr_meas();
    sw_sub = 2'b01;
    tick();
    sw_sub = '0;
    tick();
    auto_req = 2'b01;
    tick();
    auto_req = '0;
    repeat (10) tick();
    exp_low = AutoEn ? 2 + HC : HC;
    check_eq("s4_sub0_low", cnt_sub_low[0], exp_low);
    check_eq("s4_clr_sub0", cnt_clr_sub[0], 1);

    // Reset during sub 1 hold
    clr_meas();
    sw_sub = 2'b10;
    tick();
    sw_sub = '0;
    tick();
    async_reset();
    tick();
    check_eq("s5_no_clr_sub1", cnt_clr_sub[1], 0);
    rst = 1'b0;
    clr_meas();
    compare_outputs();
    repeat (7) tick();
    check_eq("s5_all_low", cnt_all_low, HC);
    check_eq("s5_sub1_low", cnt_sub_low[1], HC);
    check_eq("s5_clr_all", cnt_clr_all, 1);
    check_eq("s5_clr_sub1", cnt_clr_sub[1], 0);

    // Software bit left high: back-to-back sequences
    clr_meas();
    sw_sub = 2'b01;
    repeat (10) tick();
    sw_sub = '0;
    repeat (8) tick();
    check_eq("s6_sub0_low", cnt_sub_low[0], 2 * HC);
    check_eq("s6_clr_sub0", cnt_clr_sub[0], 2);

    // Randomized traffic with occasional asynchronous resets
    for (int k = 0; k < 1500; k++) begin
      sw_all = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NS; i++) begin
        sw_sub[i]   = ($urandom_range(0, 3) == 0);
        auto_req[i] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
